// File: rtl/instr_fetch.sv
// Fetch-stage front end: owns the PC, addresses the combinational instruction
// memory and registers the returned word with its PC into the IF/ID register.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        addr_ok;

  // Misaligned or past-the-end PCs (including ones near 2^32) never reach memory use.
  assign addr_ok = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      RUN: begin
        if (redirect_i) begin
          pc_d         = redirect_pc_i;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (!stall_i) begin
          if (addr_ok) begin
            ifid_d.instr = mem_instr_i;
            ifid_d.pc    = pc_q;
            ifid_d.pc4   = pc_q + 32'd4;
            ifid_d.valid = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_pc_d   = pc_q;
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
          end
        end
      end
      FAULT: begin
        ifid_d.valid = 1'b0;
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= 32'd0;
      ifid_q.pc4   <= 32'd0;
      ifid_q.valid <= 1'b0;
      fault_q      <= 1'b0;
      fault_pc_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign mem_addr_o = pc_q;
  assign instr_o    = ifid_q.instr;
  assign pc_o       = ifid_q.pc;
  assign pc_plus4_o = ifid_q.pc4;
  assign valid_o    = ifid_q.valid;
  assign fault_o    = fault_q;
  assign fault_pc_o = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequence, per-cycle compare against a
// behavioural fetch model, plus literal checkpoints from the test plan.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          MB  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic [31:0] mem_addr, mem_instr, instr, pc, pc4, fpc;
  logic        valid, fault;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [0:MB/4-1];

  instr_fetch #(.RESET_PC(32'h0), .MEM_BYTES(MB), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(rpc), .mem_addr_o(mem_addr), .mem_instr_i(mem_instr),
    .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc4), .valid_o(valid),
    .fault_o(fault), .fault_pc_o(fpc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a < MB) return mem[a[9:2]];
    return 32'hBAD0_BAD0;
  endfunction

  assign mem_instr = memword(mem_addr);

  // Behavioural model: what the fetch stage must show after each edge.
  bit          m_fault = 1'b0, m_valid = 1'b0;
  logic [31:0] m_pc = 32'd0, m_instr = NOP, m_pco = 32'd0, m_pc4 = 32'd0, m_fpc = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fault = 0; m_valid = 0; m_pc = 0; m_instr = NOP; m_pco = 0; m_pc4 = 0; m_fpc = 0;
    end else if (m_fault) begin
      if (redirect) begin m_pc = rpc; m_fault = 0; end
    end else if (redirect) begin
      m_pc = rpc; m_valid = 0; m_instr = NOP;
    end else if (!stall) begin
      if (m_pc % 4 == 0 && m_pc <= MB - 4) begin
        m_instr = memword(m_pc); m_pco = m_pc; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end else begin
        m_fault = 1; m_fpc = m_pc; m_valid = 0; m_instr = NOP;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("m.mem_addr", mem_addr, m_pc);
    chk("m.instr", instr, m_instr);
    chk("m.pc", pc, m_pco);
    chk("m.pc4", pc4, m_pc4);
    chk("m.valid", {31'd0, valid}, {31'd0, m_valid});
    chk("m.fault", {31'd0, fault}, {31'd0, m_fault});
    chk("m.fault_pc", fpc, m_fpc);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < MB / 4; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;

    // Reset values
    #12;
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.instr", instr, NOP);
    chk("rst.pc", pc, 32'd0);
    chk("rst.pc4", pc4, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.fault_pc", fpc, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    tick();
    rst_n = 1'b1; chk_en = 1'b1;

    // First fetches
    tick();
    chk("e1.valid", {31'd0, valid}, 32'd1);
    chk("e1.instr", instr, 32'h0050_0093);
    chk("e1.pc", pc, 32'd0);
    tick();
    chk("e2.instr", instr, 32'h0010_0113);
    chk("e2.pc", pc, 32'd4);
    chk("e2.pc4", pc4, 32'd8);

    // Stall three cycles at pc 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.mem_addr", mem_addr, 32'd8);
      chk("stall.pc", pc, 32'd4);
      chk("stall.instr", instr, 32'h0010_0113);
    end
    stall = 1'b0;
    tick();
    chk("unstall.pc", pc, 32'd8);
    chk("unstall.instr", instr, 32'h1000_0008);

    // Redirect beats stall
    redirect = 1'b1; rpc = 32'h40; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("redir.valid", {31'd0, valid}, 32'd0);
    chk("redir.instr", instr, NOP);
    chk("redir.mem_addr", mem_addr, 32'h40);
    chk("redir.pc_hold", pc, 32'd8);
    tick();
    chk("redir2.pc", pc, 32'h40);
    chk("redir2.valid", {31'd0, valid}, 32'd1);

    // Run off the end of memory
    for (int i = 0; i < 300 && !fault; i++) tick();
    chk("end.fault", {31'd0, fault}, 32'd1);
    chk("end.fault_pc", fpc, 32'h400);
    chk("end.valid", {31'd0, valid}, 32'd0);
    chk("end.mem_addr", mem_addr, 32'h400);
    chk("end.last_pc", pc, 32'h3FC);
    for (int i = 0; i < 3; i++) begin
      stall = (i % 2 == 0); tick();
      chk("fstall.fault", {31'd0, fault}, 32'd1);
      chk("fstall.mem_addr", mem_addr, 32'h400);
    end
    stall = 1'b0;
    redirect = 1'b1; rpc = 32'h0;
    tick();
    redirect = 1'b0;
    chk("recov.fault", {31'd0, fault}, 32'd0);
    chk("recov.mem_addr", mem_addr, 32'd0);
    tick();
    chk("recov.pc", pc, 32'd0);
    chk("recov.valid", {31'd0, valid}, 32'd1);

    // Misaligned redirect target
    redirect = 1'b1; rpc = 32'h6;
    tick();
    redirect = 1'b0;
    chk("mis.fault0", {31'd0, fault}, 32'd0);
    chk("mis.mem_addr", mem_addr, 32'h6);
    tick();
    chk("mis.fault", {31'd0, fault}, 32'd1);
    chk("mis.fault_pc", fpc, 32'h6);
    for (int i = 0; i < 4; i++) begin
      stall = (i % 2 == 1); tick();
      chk("mis.hold_fpc", fpc, 32'h6);
      chk("mis.hold_addr", mem_addr, 32'h6);
    end
    stall = 1'b0;

    // Target near 2^32 faults instead of wrapping
    redirect = 1'b1; rpc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("hi.fault", {31'd0, fault}, 32'd1);
    chk("hi.fault_pc", fpc, 32'hFFFF_FFFC);

    // Restart and reset mid-stream at pc 0x20
    redirect = 1'b1; rpc = 32'h0;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 20 && mem_addr != 32'h20; i++) tick();
    chk("mid.mem_addr", mem_addr, 32'h20);
    chk("mid.valid", {31'd0, valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, valid}, 32'd0);
    chk("arst.instr", instr, NOP);
    chk("arst.pc", pc, 32'd0);
    chk("arst.mem_addr", mem_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel.valid", {31'd0, valid}, 32'd1);
    chk("rel.pc", pc, 32'd0);
    chk("rel.instr", instr, 32'h0050_0093);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
